// File: rtl/booth_seq_arbiter.sv
// booth_seq_arbiter: round-robin shared iterative radix-2 Booth signed multiplier with tagged results
module booth_seq_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] res_product,
  output logic               res_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [CW-1:0] count;
  logic last_id, id, q, grant;
  logic signed [WIDTH:0] a_r, hi, sum;
  logic [WIDTH-1:0] lo;
  logic signed [2*WIDTH:0] nxt;
  // hi carries one guard bit so the most-negative operands never overflow a step
  always_comb begin
    grant = req0_valid && req1_valid ? ~last_id : req1_valid;
    req0_ready = rst_n && state == IDLE && req0_valid && !grant;
    req1_ready = rst_n && state == IDLE && req1_valid && grant;
    sum = {lo[0], q} == 2'b01 ? hi + a_r : {lo[0], q} == 2'b10 ? hi - a_r : hi;
    nxt = $signed({sum, lo}) >>> 1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      last_id <= 1'b1;
      id <= 1'b0;
      q <= 1'b0;
      a_r <= '0;
      hi <= '0;
      lo <= '0;
      res_valid <= 1'b0;
      res_product <= '0;
      res_id <= 1'b0;
      busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          a_r <= grant ? {req1_a[WIDTH-1], req1_a} : {req0_a[WIDTH-1], req0_a};
          lo <= grant ? req1_b : req0_b;
          hi <= '0;
          q <= 1'b0;
          count <= '0;
          id <= grant;
          last_id <= grant;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          hi <= nxt[2*WIDTH:WIDTH];
          lo <= nxt[WIDTH-1:0];
          q <= lo[0];
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= DONE;
            res_valid <= 1'b1;
            res_product <= nxt[2*WIDTH-1:0];
            res_id <= id;
          end
        end
        DONE: if (res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_arbiter.sv
// tb_booth_seq_arbiter: randomized handshake/latency/product checks against a transaction-level model
module tb_booth_seq_arbiter;
  localparam int W = 5;
  logic clk = 0, rst_n = 1;
  logic req0_valid = 0, req1_valid = 0, res_ready = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, res_valid, res_id, busy;
  logic [2*W-1:0] res_product;
  booth_seq_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .res_id(res_id), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [2*W-1:0] q0[$], q1[$];
  logic got_ids[$];
  int rr_mode = 0;
  bit acc0, acc1, g0, g1;
  bit m_free = 1, m_done = 0, m_last = 1;
  int m_cnt = 0;
  logic [2*W-1:0] m_hp = 0, e_p = 0;
  logic m_hid = 0, e_id = 0;
  task automatic push(input bit who, input int a, input int b);
    logic [2*W-1:0] v;
    v = {a[W-1:0], b[W-1:0]};
    if (who) q1.push_back(v); else q0.push_back(v);
  endtask
  initial forever begin
    @(posedge clk); #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    acc0 = 0; acc1 = 0;
    req0_valid = q0.size() > 0;
    req1_valid = q1.size() > 0;
    if (q0.size() > 0) {req0_a, req0_b} = q0[0];
    if (q1.size() > 0) {req1_a, req1_b} = q1[0];
    res_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  // reference: engine is free, computing (a fixed W-clock wait), or holding a result
  always @(negedge clk) begin
    if (!rst_n) begin
      m_free = 1; m_done = 0; m_last = 1; m_cnt = 0; m_hp = 0; m_hid = 0;
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rv", res_valid, 0);
      check("rst_prod", res_product, 0);
      check("rst_id", res_id, 0);
    end else begin
      g0 = m_free && req0_valid && (!req1_valid || m_last);
      g1 = m_free && req1_valid && (!req0_valid || !m_last);
      check("rdy0", req0_ready, g0);
      check("rdy1", req1_ready, g1);
      check("busy", busy, !m_free);
      check("res_valid", res_valid, m_done);
      check("res_product", res_product, m_hp);
      check("res_id", res_id, m_hid);
      acc0 = g0; acc1 = g1;
      if (g0 || g1) begin
        int sa, sb, p;
        logic signed [W-1:0] ea, eb;
        ea = g1 ? req1_a : req0_a;
        eb = g1 ? req1_b : req0_b;
        sa = ea; sb = eb; p = sa * sb;
        e_p = p[2*W-1:0]; e_id = g1;
        m_free = 0; m_cnt = W; m_last = g1;
      end else if (m_done) begin
        if (res_ready) begin
          got_ids.push_back(res_id);
          m_done = 0; m_free = 1;
        end
      end else if (!m_free) begin
        m_cnt--;
        if (m_cnt == 0) begin m_done = 1; m_hp = e_p; m_hid = e_id; end
      end
    end
  end
  task automatic drain(input int budget);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || !m_free) && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check("drain_timeout", k < budget, 1);
    @(posedge clk); #1;
  endtask
  initial begin
    int k, lat;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    repeat (10) @(posedge clk);
    push(0, 3, -2);
    k = 0;
    while (m_free && k < 20) begin @(negedge clk); #1; k++; end
    @(posedge clk);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!res_valid && lat < 20);
    check("latency", lat, W);
    drain(50);
    check("p_3x-2", res_product, 10'h3FA);
    check("id_3x-2", res_id, 0);
    push(1, -16, -16); drain(50); check("p_m16m16", res_product, 10'h100); check("id_c1", res_id, 1);
    push(1, -16, 15);  drain(50); check("p_m16x15", res_product, 10'h310); check("id_c2", res_id, 1);
    push(1, 15, 15);   drain(50); check("p_15x15", res_product, 10'h0E1); check("id_c3", res_id, 1);
    push(1, 0, -16);   drain(50); check("p_0xm16", res_product, 10'h000); check("id_c4", res_id, 1);
    got_ids.delete();
    for (int i = 0; i < 3; i++) begin
      push(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      push(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
    drain(200);
    check("rr_count", got_ids.size(), 6);
    for (int i = 0; i < 6 && i < got_ids.size(); i++) check("rr_order", got_ids[i], i % 2);
    rr_mode = 2;
    push(1, 6, -7);
    k = 0;
    while (!m_done && k < 30) begin @(negedge clk); #1; k++; end
    push(0, 5, 5);
    repeat (12) @(negedge clk);
    check("stall_rv", res_valid, 1);
    check("stall_busy", busy, 1);
    check("stall_prod", res_product, 10'h3D6);
    rr_mode = 0;
    drain(80);
    check("after_stall", res_product, 10'h019);
    push(0, 9, -11);
    k = 0;
    while (m_free && k < 20) begin @(negedge clk); #1; k++; end
    repeat (4) @(posedge clk);
    #2 rst_n = 0;
    q0.delete(); q1.delete();
    req0_valid = 0; req1_valid = 0;
    #1;
    check("async_busy", busy, 0);
    check("async_prod", res_product, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    push(0, -5, 7);
    drain(50);
    check("p_m5x7", res_product, 10'h3DD);
    check("id_m5x7", res_id, 0);
    rr_mode = 1;
    for (int a = -16; a < 16; a++)
      for (int b = -16; b < 16; b++) push(1'((a + b) & 1), a, b);
    drain(40000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
